// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle memory between a fetch port and a data port,
// favouring data accesses but promoting a fetch that has waited MAX_WAIT cycles.
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
    owner_t     owner;
    logic [3:0] wait_cnt;
    logic       starved;
    // grants are gated by reset so they drop the instant reset asserts
    always_comb begin
        starved = wait_cnt == 4'(MAX_WAIT);
        i_gnt   = reset & i_req & (~d_req | starved);
        d_gnt   = reset & d_req & ~i_gnt;
        m_en    = i_gnt | d_gnt;
        m_we    = d_gnt & d_we;
        m_addr  = d_gnt ? d_addr : i_addr;
        m_wdata = d_wdata;
    end
    assign i_rvalid = owner == OWN_I;
    assign d_rvalid = owner == OWN_D;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            owner    <= OWN_NONE;
        end else begin
            wait_cnt <= (i_req & ~i_gnt) ? (starved ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
            owner    <= i_gnt ? OWN_I : (d_gnt & ~d_we) ? OWN_D : OWN_NONE;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// cycle-level model of the arbitration rules and a shadow memory.
module tb_mem_arbiter;
    localparam int MAX_WAIT = 4;

    logic        clk = 0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    int          deny;
    bit          pend_i, pend_d, last_ei, last_ed;
    logic [31:0] exp_data;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // single-cycle synchronous memory seen by the arbiter
    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr[7:2]] <= m_wdata;
        if (m_en && !m_we) m_rdata <= mem[m_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        deny    = 0;
        pend_i  = 0;
        pend_d  = 0;
        last_ei = 0;
        last_ed = 0;
    endtask

    // one clock cycle: check at negedge against the rules, then advance the model
    task automatic cycle();
        bit ei, ed;
        @(negedge clk);
        ei = i_req && (!d_req || deny == MAX_WAIT);
        ed = d_req && !ei;
        chk("i_gnt", i_gnt, ei);
        chk("d_gnt", d_gnt, ed);
        chk("both_gnt", i_gnt & d_gnt, 0);
        chk("m_en", m_en, ei | ed);
        chk("m_we", m_we, ed & d_we);
        chk("m_addr", m_addr, ed ? d_addr : i_addr);
        chk("m_wdata", m_wdata, d_wdata);
        chk("i_rvalid", i_rvalid, pend_i);
        chk("d_rvalid", d_rvalid, pend_d);
        if (pend_i) chk("i_rdata", i_rdata, exp_data);
        if (pend_d) chk("d_rdata", d_rdata, exp_data);
        pend_i = ei;
        pend_d = ed && !d_we;
        if (ei) exp_data = ref_mem[i_addr[7:2]];
        if (ed && !d_we) exp_data = ref_mem[d_addr[7:2]];
        if (ed && d_we) ref_mem[d_addr[7:2]] = d_wdata;
        deny = (i_req && !ei) ? ((deny + 1 > MAX_WAIT) ? MAX_WAIT : deny + 1) : 0;
        last_ei = ei;
        last_ed = ed;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem[k]     = 32'hA5A5_0000 + 32'(k * 7);
            ref_mem[k] = 32'hA5A5_0000 + 32'(k * 7);
        end
        mem[4]     = 32'h0050_0113;
        ref_mem[4] = 32'h0050_0113;
        model_reset();

        // reset held with both requests high: everything must stay quiet
        reset = 0; i_req = 1; d_req = 1; d_we = 1;
        i_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h0;
        #2;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_m_en", m_en, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        @(posedge clk);
        #1;
        reset = 1;
        i_req = 0; d_req = 0; d_we = 0;

        // fetch from 0x10 granted in the first cycle after reset
        i_req = 1; i_addr = 32'h10;
        cycle();
        i_req = 0;
        cycle();

        // store then load of the same word
        d_req = 1; d_we = 1; d_addr = 32'h64; d_wdata = 32'h19;
        cycle();
        d_we = 0;
        cycle();
        d_req = 0;
        cycle();
        chk("mem_store", mem[25], 32'h19);

        // contention: fetch must win on the fifth cycle
        i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h30;
        for (int k = 0; k < 12; k++) cycle();
        i_req = 0; d_req = 0;
        cycle();

        // alternating fetch/load, a response every cycle
        for (int k = 0; k < 10; k++) begin
            i_req = k[0] == 0;
            d_req = k[0] == 1;
            d_we = 0;
            i_addr = 32'(k * 8);
            d_addr = 32'(k * 8 + 4);
            cycle();
        end
        i_req = 0; d_req = 0;
        cycle();

        // randomized traffic with requests held until granted
        for (int k = 0; k < 400; k++) begin
            if (!i_req || last_ei) begin
                i_req  = $urandom_range(0, 3) != 0;
                i_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!d_req || last_ed) begin
                d_req   = $urandom_range(0, 3) != 0;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                d_wdata = $urandom;
            end
            cycle();
        end
        i_req = 0; d_req = 0;
        cycle();

        // reset asserted mid-cycle while a fetch response and a new grant are live
        i_req = 1; i_addr = 32'h10;
        cycle();
        chk("pre_rst_i_rvalid", i_rvalid, 1);
        chk("pre_rst_i_gnt", i_gnt, 1);
        #1;
        reset = 0;
        #1;
        chk("midrst_i_rvalid", i_rvalid, 0);
        chk("midrst_i_gnt", i_gnt, 0);
        chk("midrst_m_en", m_en, 0);
        @(posedge clk);
        #1;
        reset = 1;
        model_reset();
        i_req = 0;
        cycle();

        // wait counter restarts from zero after reset
        i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h44;
        for (int k = 0; k < 7; k++) cycle();
        i_req = 0; d_req = 0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
